// File: rtl/scan_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scan_sequencer_if                                                   |
// | Scan control and 2-to-4 decoder select/enable bundle.               |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
interface scan_sequencer_if;
  logic       run;
  logic [3:0] mask;
  logic [1:0] a;
  logic       e;
  logic       frame;

  modport master (input run, input mask, output a, output e, output frame);
  modport slave  (output run, output mask, input a, input e, input frame);
endinterface

`default_nettype wire

// File: rtl/scan_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | scan_sequencer                                                      |
// | Round-robin select/enable generator for a 2-to-4 decoder, with a    |
// | one-cycle blanking guard at the start of every slot.                |
// | Option macro: SCAN_SKIP_EN (masked slots are skipped, not blanked). |
// | Rev 1.0 - initial release                                           |
// +--------------------------------------------------------------------+
module scan_sequencer #(
  parameter int DWELL = 8
) (
  input  logic              clk,
  input  logic              rst,
  scan_sequencer_if.master  bus
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

  // HOLD is the parked guard used only when every slot is masked off in skip mode.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    ON    = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             mlat;
  logic [1:0]       a_q;
  logic             e_q;
  logic             frame_q;
  logic [1:0]       next_a;
  logic             next_valid;

  always_comb begin
    next_a     = a_q + 2'd1;
    next_valid = 1'b1;
`ifdef SCAN_SKIP_EN
    next_valid = |bus.mask;
    next_a     = a_q;
    // Descending scan so the nearest set bit after a_q wins; i=4 wraps to a_q itself.
    for (int i = 4; i >= 1; i--) begin
      if (bus.mask[a_q + 2'(i)]) begin
        next_a = a_q + 2'(i);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mlat    <= 1'b0;
      a_q     <= 2'd0;
      e_q     <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      e_q     <= 1'b0;
      frame_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.run) begin
            state <= GUARD;
            cnt   <= '0;
          end
        end
        GUARD: begin
          if (!bus.run) begin
            state <= IDLE;
          end else begin
            mlat  <= bus.mask[a_q];
            e_q   <= bus.mask[a_q];
            cnt   <= CNT_W'(1);
            state <= ON;
          end
        end
        ON: begin
          if (!bus.run) begin
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (next_valid) begin
              a_q     <= next_a;
              frame_q <= (next_a <= a_q);
              state   <= GUARD;
            end else begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + 1'b1;
            e_q <= mlat;
          end
        end
        HOLD: begin
          if (!bus.run) begin
            state <= IDLE;
          end else if (next_valid) begin
            a_q     <= next_a;
            frame_q <= (next_a <= a_q);
            state   <= GUARD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.a     = a_q;
  assign bus.e     = e_q;
  assign bus.frame = frame_q;

endmodule

`default_nettype wire
